// File: rtl/mmu_tile_sequencer_pkg.sv
// Shared FSM encodings and operand-layout helpers for the MMU tile sequencer.
package mmu_tile_sequencer_pkg;

  localparam logic [1:0] ST_LOAD    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  function automatic int b_base(input int r, input int k);
    return r * k;
  endfunction

  function automatic int c_base(input int r, input int k, input int n);
    return r * k + k * n;
  endfunction

  function automatic int total_words(input int r, input int k, input int n);
    return c_base(r, k, n) + r * n;
  endfunction

endpackage

// File: rtl/mmu_tile_sequencer_if.sv
// Operand stream, result stream and parallel MMU bus of the tile sequencer.
interface mmu_tile_sequencer_if #(
  parameter int NUM_ROWS_A = 2,
  parameter int NUM_COLS_A = 2,
  parameter int NUM_COLS_B = 2,
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  mmu_enable;
  logic                  mmu_data_ready;
  logic [NUM_ROWS_A-1:0][NUM_COLS_A-1:0][DATA_WIDTH-1:0] mmu_mat_in1;
  logic [NUM_COLS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] mmu_mat_in2;
  logic [NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] mmu_mat_in_accum;
  logic [NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] mmu_mat_out;

  modport master (
    input  in_valid, in_data, out_ready, mmu_data_ready, mmu_mat_out,
    output in_ready, out_valid, out_data, out_last, mmu_enable,
           mmu_mat_in1, mmu_mat_in2, mmu_mat_in_accum
  );

  modport slave (
    output in_valid, in_data, out_ready, mmu_data_ready, mmu_mat_out,
    input  in_ready, out_valid, out_data, out_last, mmu_enable,
           mmu_mat_in1, mmu_mat_in2, mmu_mat_in_accum
  );
endinterface

// File: rtl/mmu_result_drain.sv
// Holds the captured result matrix and unloads it word-serially, row-major.
module mmu_result_drain #(
  parameter int NUM_WORDS  = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 load,
  input  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] load_data,
  input  logic                                 out_ready,
  output logic                                 out_valid,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic                                 out_last,
  output logic                                 done
);
  localparam int IW = $clog2(NUM_WORDS + 1);

  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] res;
  logic [IW-1:0]                        idx;
  logic                                 active;
  logic                                 hs;
  logic                                 at_last;

  assign at_last   = (idx == IW'(NUM_WORDS - 1));
  assign hs        = active && out_ready;
  assign done      = hs && at_last;
  assign out_valid = active;
  assign out_last  = active && at_last;

  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_WORDS; i++)
      if (idx == IW'(i)) out_data = res[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res    <= '0;
      idx    <= '0;
      active <= 1'b0;
    end else if (load) begin
      res    <= load_data;
      idx    <= '0;
      active <= 1'b1;
    end else if (hs) begin
      if (at_last) begin
        idx    <= '0;
        active <= 1'b0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmu_tile_sequencer.sv
// Loads A/B/C word-serially, runs one MMU operation with timeout, drains the result.
module mmu_tile_sequencer
  import mmu_tile_sequencer_pkg::*;
#(
  parameter int NUM_ROWS_A     = 2,
  parameter int NUM_COLS_A     = 2,
  parameter int NUM_COLS_B     = 2,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  mmu_tile_sequencer_if.master bus,
  output logic                busy,
  output logic                err_timeout
);
  localparam int RN    = NUM_ROWS_A * NUM_COLS_B;
  localparam int BB    = b_base(NUM_ROWS_A, NUM_COLS_A);
  localparam int CB    = c_base(NUM_ROWS_A, NUM_COLS_A, NUM_COLS_B);
  localparam int TOTAL = total_words(NUM_ROWS_A, NUM_COLS_A, NUM_COLS_B);
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int WW    = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]                       state;
  logic [CW-1:0]                    ld_cnt;
  logic [WW-1:0]                    wait_cnt;
  logic [TOTAL-1:0][DATA_WIDTH-1:0] opnd;
  logic                             in_hs;
  logic                             cap;
  logic                             tmo;
  logic                             drain_done;
  logic [RN-1:0][DATA_WIDTH-1:0]    cap_data;

  assign bus.in_ready   = (state == ST_LOAD) && !rst;
  assign in_hs          = bus.in_valid && bus.in_ready;
  assign bus.mmu_enable = (state == ST_COMPUTE);
  assign busy           = (state != ST_LOAD);

  // The first COMPUTE cycle sees a data_ready level left over from the previous operation.
  assign cap      = (state == ST_COMPUTE) && (wait_cnt != '0) && bus.mmu_data_ready;
  assign tmo      = (state == ST_COMPUTE) && !cap && (wait_cnt == WW'(TIMEOUT_CYCLES - 1));
  assign cap_data = tmo ? '0 : bus.mmu_mat_out;

  assign bus.mmu_mat_in1      = opnd[BB-1:0];
  assign bus.mmu_mat_in2      = opnd[CB-1:BB];
  assign bus.mmu_mat_in_accum = opnd[TOTAL-1:CB];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_LOAD;
      ld_cnt      <= '0;
      wait_cnt    <= '0;
      opnd        <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: if (in_hs) begin
          for (int i = 0; i < TOTAL; i++)
            if (ld_cnt == CW'(i)) opnd[i] <= bus.in_data;
          if (ld_cnt == CW'(TOTAL - 1)) begin
            ld_cnt   <= '0;
            wait_cnt <= '0;
            state    <= ST_COMPUTE;
          end else begin
            ld_cnt <= ld_cnt + 1'b1;
          end
        end
        ST_COMPUTE: begin
          if (cap || tmo) state <= ST_DRAIN;
          else            wait_cnt <= wait_cnt + 1'b1;
          if (tmo) err_timeout <= 1'b1;
        end
        ST_DRAIN: if (drain_done) state <= ST_LOAD;
        default: state <= ST_LOAD;
      endcase
    end
  end

  mmu_result_drain #(
    .NUM_WORDS (RN),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_drain (
    .clk      (clk),
    .rst      (rst),
    .load     (cap || tmo),
    .load_data(cap_data),
    .out_ready(bus.out_ready),
    .out_valid(bus.out_valid),
    .out_data (bus.out_data),
    .out_last (bus.out_last),
    .done     (drain_done)
  );

endmodule

// File: tb/tb_mmu_tile_sequencer.sv
// Directed bench for mmu_tile_sequencer against a behavioural Q8.8 mmu_short model.
module tb_mmu_tile_sequencer;
  localparam int R = 2, K = 2, N = 2, DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, err_timeout;
  int   errs = 0, checks = 0;
  int   mode = 0;  // 0 normal, 1 never ready, 2 stale ready before enable
  int   mcnt = 0;

  logic [15:0] ops [12] = '{16'h0100, 16'h0200, 16'h0300, 16'h0180,
                            16'h0400, 16'h0300, 16'h0200, 16'h0280,
                            16'h0100, 16'h0100, 16'h0100, 16'h0100};
  localparam logic [63:0] EXP1   = 64'h0DC0_1000_0900_0900;
  localparam logic [63:0] EX_IN1 = 64'h0180_0300_0200_0100;
  localparam logic [63:0] EX_IN2 = 64'h0280_0200_0300_0400;
  localparam logic [63:0] EX_ACC = 64'h0100_0100_0100_0100;
  localparam logic [63:0] JUNK   = 64'hBAD0_BAD0_BAD0_BAD0;

  always #5 clk = ~clk;

  mmu_tile_sequencer_if #(.NUM_ROWS_A(R), .NUM_COLS_A(K), .NUM_COLS_B(N), .DATA_WIDTH(DW)) bus ();

  mmu_tile_sequencer #(
    .NUM_ROWS_A(R), .NUM_COLS_A(K), .NUM_COLS_B(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .err_timeout(err_timeout)
  );

  function automatic logic [R-1:0][N-1:0][DW-1:0] mmu_calc();
    logic [R-1:0][N-1:0][DW-1:0] res;
    int acc;
    for (int ri = 0; ri < R; ri++)
      for (int ni = 0; ni < N; ni++) begin
        acc = 0;
        for (int ki = 0; ki < K; ki++)
          acc += int'($signed(bus.mmu_mat_in1[ri][ki])) * int'($signed(bus.mmu_mat_in2[ki][ni]));
        res[ri][ni] = DW'((acc >>> 8) + int'($signed(bus.mmu_mat_in_accum[ri][ni])));
      end
    return res;
  endfunction

  // mmu_short model: ready three cycles after enable rises; stale mode holds ready high while idle.
  always @(posedge clk) begin
    if (!bus.mmu_enable) begin
      mcnt               <= 0;
      bus.mmu_data_ready <= (mode == 2);
      bus.mmu_mat_out    <= JUNK;
    end else begin
      mcnt               <= mcnt + 1;
      bus.mmu_data_ready <= (mode != 1) && (mcnt >= 2);
      bus.mmu_mat_out    <= (mcnt >= 2) ? mmu_calc() : JUNK;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops(input bit gaps);
    int n = 0, cyc = 0;
    bit hs;
    while (n < 12 && cyc < 200) begin
      bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data  = bus.in_valid ? ops[4'(n)] : 16'hFFFF;
      if (cyc == 0) chk("ld_in_ready", 64'(bus.in_ready), 64'd1);
      hs = bus.in_valid && bus.in_ready;
      step();
      if (hs) n++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("ld_words", 64'(n), 64'd12);
  endtask

  task automatic compute_wait(input int exp_en);
    int cyc = 0, en = 0;
    while (!bus.out_valid && cyc < 300) begin
      chk("cmp_in_ready", 64'(bus.in_ready), 64'd0);
      if (bus.mmu_enable) begin
        en++;
        if (en == 1) chk("in1_11", 64'(bus.mmu_mat_in1[1][1]), 64'h0180);
        chk("in1", 64'(bus.mmu_mat_in1), EX_IN1);
        chk("in2", 64'(bus.mmu_mat_in2), EX_IN2);
        chk("acc", 64'(bus.mmu_mat_in_accum), EX_ACC);
      end
      step();
      cyc++;
    end
    chk("cmp_out_valid", 64'(bus.out_valid), 64'd1);
    chk("cmp_en_cycles", 64'(en), 64'(exp_en));
    chk("cmp_en_low", 64'(bus.mmu_enable), 64'd0);
  endtask

  task automatic drain(input logic [6:0] pat, input int plen, input logic [63:0] expw);
    int n = 0, cyc = 0;
    bit stall = 1'b0;
    logic [15:0] pd;
    logic pl;
    while (n < 4 && cyc < 100) begin
      bus.out_ready = pat[3'(cyc % plen)];
      chk("drn_in_ready", 64'(bus.in_ready), 64'd0);
      if (stall) begin
        chk("stall_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_data", 64'(bus.out_data), 64'(pd));
        chk("stall_last", 64'(bus.out_last), 64'(pl));
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("drn_word", 64'(bus.out_data), 64'(expw[n*16 +: 16]));
        chk("drn_last", 64'(bus.out_last), 64'(n == 3));
        n++;
      end
      stall = bus.out_valid && !bus.out_ready;
      pd = bus.out_data;
      pl = bus.out_last;
      step();
      cyc++;
    end
    bus.out_ready = 1'b0;
    chk("drn_words", 64'(n), 64'd4);
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_in_ready", 64'(bus.in_ready), 64'd1);
    chk("end_out_valid", 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    int n, cyc;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b0;
    step();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_enable", 64'(bus.mmu_enable), 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 64'(bus.in_ready), 64'd1);

    // basic run
    load_ops(1'b0); compute_wait(4); drain(7'h7F, 1, EXP1);
    // back-pressure 1,0,0,1,0,1,1
    load_ops(1'b0); compute_wait(4); drain(7'b1101001, 7, EXP1);
    // input gaps
    load_ops(1'b1); compute_wait(4); drain(7'h7F, 1, EXP1);

    // timeout
    mode = 1;
    load_ops(1'b0); compute_wait(64);
    chk("tmo_err", 64'(err_timeout), 64'd1);
    drain(7'h7F, 1, 64'd0);
    chk("tmo_err_sticky", 64'(err_timeout), 64'd1);

    // reset mid-drain
    mode = 0;
    load_ops(1'b0); compute_wait(4);
    n = 0; cyc = 0;
    while (n < 2 && cyc < 20) begin
      bus.out_ready = 1'b1;
      if (bus.out_valid) n++;
      step();
      cyc++;
    end
    chk("rst_mid_words", 64'(n), 64'd2);
    chk("rst_mid_valid_pre", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    step();
    chk("rst_mid_in_ready_hold", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_mid_err", 64'(err_timeout), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    load_ops(1'b0); compute_wait(4); drain(7'h7F, 1, EXP1);

    // stale ready
    mode = 2;
    load_ops(1'b0); compute_wait(4); drain(7'h7F, 1, EXP1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
